// File: rtl/debug_bram_dumper.sv
// debug_bram_dumper
//   Walks word_count consecutive words of an Inst/Data BRAM through its
//   debug port (A2/WD2/WE2/RD2) and streams {addr,data} over valid/ready.
//   Read-only: WD2/WE2 are tied off.
//
//   Optional feature macro: DUMP_CHECKSUM_EN
//     defined   -> checksum = mod-2^32 sum of all words transferred in the
//                  current request (cleared at accepted start)
//     undefined -> checksum tied to 0
//
// Ports
//   CPU_CLK, CPU_RST        clock (posedge), async active-low reset
//   start                   1-cycle request, sampled only in IDLE
//   base_addr, word_count   request, latched at accepted start
//   busy, done              status; done is a 1-cycle pulse
//   Debug_A2/WD2/WE2/RD2    BRAM debug port (RD2 valid 1 cycle after A2)
//   m_valid/m_ready         output stream handshake
//   m_addr, m_data, m_last  stream payload
//   checksum                see macro note above
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads (at most 2 words buffered or in flight)
// DRAIN | all reads issued, emptying the buffer (also the one-cycle
//       | busy slot of an empty request)
// DONE  | done pulse, busy low, back to IDLE

module debug_bram_dumper #(
  parameter int BRAMWORDS = 4096,
  parameter int CNT_W     = 13
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      Debug_A2,
  output logic [31:0]      Debug_WD2,
  output logic [3:0]       Debug_WE2,
  input  logic [31:0]      Debug_RD2,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic [31:0]      checksum
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] WRAP_ADDR = 32'(BRAMWORDS * 4 - 4);

  logic [1:0]       state;
  logic [31:0]      curAddr;
  logic [31:0]      lastA2;
  logic [CNT_W-1:0] remIssue;
  logic [CNT_W-1:0] remXfer;

  logic             inflValid;
  logic [31:0]      inflAddr;
  logic             inflLast;

  logic [31:0]      fifoAddr [0:1];
  logic [31:0]      fifoData [0:1];
  logic [1:0]       fifoLast;
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       occ;

  logic             push;
  logic             pop;
  logic             issue;
  logic [2:0]       pending;
  logic [31:0]      nextAddr;
  logic             accept;

  assign Debug_WD2 = 32'h0;
  assign Debug_WE2 = 4'b0000;

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  assign m_valid = (occ != 2'd0);
  assign m_addr  = fifoAddr[rdPtr];
  assign m_data  = fifoData[rdPtr];
  assign m_last  = m_valid && fifoLast[rdPtr];

  assign accept  = (state == ST_IDLE) && start;
  assign push    = inflValid;
  assign pop     = m_valid && m_ready;
  assign pending = {1'b0, occ} + {2'b00, inflValid};
  // A slot freed by this cycle's pop may be refilled by this cycle's read,
  // which keeps one word per cycle flowing while m_ready stays high.
  assign issue   = (state == ST_RUN) && ((pending < 3'd2) || pop);

  assign nextAddr = (curAddr == WRAP_ADDR) ? 32'h0 : curAddr + 32'd4;

  // The BRAM samples A2 on the edge that ends the issue cycle, so the
  // address is presented combinationally and remembered for idle cycles.
  assign Debug_A2 = issue ? curAddr : lastA2;

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      state     <= ST_IDLE;
      curAddr   <= 32'h0;
      lastA2    <= 32'h0;
      remIssue  <= '0;
      remXfer   <= '0;
      inflValid <= 1'b0;
      inflAddr  <= 32'h0;
      inflLast  <= 1'b0;
    end else begin
      inflValid <= issue;
      if (issue) begin
        lastA2   <= curAddr;
        inflAddr <= curAddr;
        inflLast <= (remIssue == CNT_W'(1));
        curAddr  <= nextAddr;
        remIssue <= remIssue - CNT_W'(1);
      end
      if (pop) begin
        remXfer <= remXfer - CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            curAddr  <= base_addr & ~32'h3;
            remIssue <= word_count;
            remXfer  <= word_count;
            state    <= (word_count == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue && (remIssue == CNT_W'(1))) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((remXfer == '0) || (pop && (remXfer == CNT_W'(1)))) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      for (int i = 0; i < 2; i++) begin
        fifoAddr[i] <= 32'h0;
        fifoData[i] <= 32'h0;
      end
      fifoLast <= 2'b00;
      wrPtr    <= 1'b0;
      rdPtr    <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (push) begin
        fifoAddr[wrPtr] <= inflAddr;
        fifoData[wrPtr] <= Debug_RD2;
        fifoLast[wrPtr] <= inflLast;
        wrPtr           <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [31:0] csum;

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      csum <= 32'h0;
    end else if (accept) begin
      csum <= 32'h0;
    end else if (pop) begin
      csum <= csum + m_data;
    end
  end

  assign checksum = csum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_debug_bram_dumper.sv
// tb_debug_bram_dumper
//   Directed bench for debug_bram_dumper with a synchronous-read BRAM model
//   on the debug port. Inputs are driven and outputs sampled on negedge.

module tb_debug_bram_dumper;

  localparam int CNT_W = 13;

  logic             CPU_CLK;
  logic             CPU_RST;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             done;
  logic [31:0]      Debug_A2;
  logic [31:0]      Debug_WD2;
  logic [3:0]       Debug_WE2;
  logic [31:0]      Debug_RD2;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_addr;
  logic [31:0]      m_data;
  logic             m_last;
  logic [31:0]      checksum;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

`ifdef DUMP_CHECKSUM_EN
  localparam logic [31:0] CS_T1 = 32'd18;
`else
  localparam logic [31:0] CS_T1 = 32'd0;
`endif

  debug_bram_dumper #(.BRAMWORDS(4096), .CNT_W(CNT_W)) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST    (CPU_RST),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .Debug_A2   (Debug_A2),
    .Debug_WD2  (Debug_WD2),
    .Debug_WE2  (Debug_WE2),
    .Debug_RD2  (Debug_RD2),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .m_last     (m_last),
    .checksum   (checksum)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  always @(posedge CPU_CLK) Debug_RD2 <= mem[Debug_A2[13:2]];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doStart(input logic [31:0] base, input int cnt);
    base_addr  = base;
    word_count = CNT_W'(cnt);
    start      = 1'b1;
    @(negedge CPU_CLK);
    start      = 1'b0;
  endtask

  // Consumes n words; checks order, payload, m_last, hold during stalls,
  // and the done pulse in the cycle after the last transfer.
  task automatic collect(input int n, input logic [31:0] base, input bit randReady);
    logic [31:0] expA;
    logic [31:0] pA;
    logic [31:0] pD;
    logic        pL;
    int          idx;
    int          budget;
    bit          stall;
    expA   = base & ~32'h3;
    idx    = 0;
    budget = 0;
    stall  = 1'b0;
    pA = 0; pD = 0; pL = 0;
    while (idx < n && budget < 500) begin
      m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        check32("stall_valid", {31'b0, m_valid}, 32'd1);
        check32("stall_addr", m_addr, pA);
        check32("stall_data", m_data, pD);
        check32("stall_last", {31'b0, m_last}, {31'b0, pL});
      end
      if (m_valid && m_ready) begin
        check32("xfer_addr", m_addr, expA);
        check32("xfer_data", m_data, mem[expA[13:2]]);
        check32("xfer_last", {31'b0, m_last}, {31'b0, (idx == n - 1)});
        idx++;
        expA  = (expA == 32'h3FFC) ? 32'h0 : expA + 32'd4;
        stall = 1'b0;
      end else if (m_valid) begin
        stall = 1'b1;
        pA = m_addr; pD = m_data; pL = m_last;
      end else begin
        stall = 1'b0;
      end
      @(negedge CPU_CLK);
      budget++;
    end
    m_ready = 1'b1;
    check32("xfer_count", 32'(idx), 32'(n));
    check32("done_after_last", {31'b0, done}, 32'd1);
    check32("busy_at_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check32({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check32({tag, "_done"}, {31'b0, done}, 32'd0);
    check32({tag, "_valid"}, {31'b0, m_valid}, 32'd0);
    check32({tag, "_last"}, {31'b0, m_last}, 32'd0);
    check32({tag, "_a2"}, Debug_A2, 32'h0);
    check32({tag, "_maddr"}, m_addr, 32'h0);
    check32({tag, "_mdata"}, m_data, 32'h0);
    check32({tag, "_csum"}, checksum, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i * 3);
    CPU_RST    = 1'b0;
    start      = 1'b0;
    base_addr  = 32'h0;
    word_count = '0;
    m_ready    = 1'b1;

    // reset state
    #2;
    checkAllZero("reset");
    check32("reset_wd2", Debug_WD2, 32'h0);
    check32("reset_we2", {28'b0, Debug_WE2}, 32'h0);
    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);

    // test 1: base 0, count 4, m_ready high
    doStart(32'h0, 4);
    check32("t1_busy_c1", {31'b0, busy}, 32'd1);
    check32("t1_valid_c1", {31'b0, m_valid}, 32'd0);
    @(negedge CPU_CLK);
    check32("t1_valid_c2", {31'b0, m_valid}, 32'd0);
    @(negedge CPU_CLK);
    for (int i = 0; i < 4; i++) begin
      check32("t1_valid", {31'b0, m_valid}, 32'd1);
      check32("t1_addr", m_addr, 32'(i * 4));
      check32("t1_data", m_data, 32'(i * 3));
      check32("t1_last", {31'b0, m_last}, {31'b0, (i == 3)});
      check32("t1_busy", {31'b0, busy}, 32'd1);
      @(negedge CPU_CLK);
    end
    check32("t1_done", {31'b0, done}, 32'd1);
    check32("t1_busy_done", {31'b0, busy}, 32'd0);
    check32("t1_valid_done", {31'b0, m_valid}, 32'd0);
    check32("t1_csum", checksum, CS_T1);
    @(negedge CPU_CLK);
    check32("t1_done_pulse", {31'b0, done}, 32'd0);
    check32("t1_csum_hold", checksum, CS_T1);

    // test 2: empty request
    doStart(32'h80, 0);
    check32("t2_busy_c1", {31'b0, busy}, 32'd1);
    check32("t2_done_c1", {31'b0, done}, 32'd0);
    check32("t2_a2_c1", Debug_A2, 32'hC);
    check32("t2_valid_c1", {31'b0, m_valid}, 32'd0);
    @(negedge CPU_CLK);
    check32("t2_done_c2", {31'b0, done}, 32'd1);
    check32("t2_busy_c2", {31'b0, busy}, 32'd0);
    check32("t2_a2_c2", Debug_A2, 32'hC);
    check32("t2_valid_c2", {31'b0, m_valid}, 32'd0);
    check32("t2_csum", checksum, 32'h0);
    @(negedge CPU_CLK);
    check32("t2_done_c3", {31'b0, done}, 32'd0);

    // test 3: address wrap
    doStart(32'h3FF8, 4);
    collect(4, 32'h3FF8, 1'b0);
    @(negedge CPU_CLK);

    // test 4: random back-pressure, unaligned base bits ignored
    doStart(32'h0000_0203, 8);
    collect(8, 32'h0000_0200, 1'b1);
    @(negedge CPU_CLK);

    // test 5: reset mid-dump
    doStart(32'h100, 16);
    repeat (5) @(negedge CPU_CLK);
    check32("t5_pre_valid", {31'b0, m_valid}, 32'd1);
    check32("t5_pre_addr", m_addr, 32'h10C);
    CPU_RST = 1'b0;
    #1;
    checkAllZero("t5_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge CPU_CLK);
      check32("t5_rst_done", {31'b0, done}, 32'd0);
    end
    CPU_RST = 1'b1;
    @(negedge CPU_CLK);
    check32("t5_post_done", {31'b0, done}, 32'd0);
    check32("t5_post_busy", {31'b0, busy}, 32'd0);
    doStart(32'h40, 2);
    collect(2, 32'h40, 1'b0);
    @(negedge CPU_CLK);

    // test 6: checksum wrap and start ignored while busy
    mem[128] = 32'hFFFF_FFFF;
    mem[129] = 32'hFFFF_FFFF;
    mem[130] = 32'h0000_0002;
    doStart(32'h200, 3);
    base_addr  = 32'h0;
    word_count = CNT_W'(5);
    start      = 1'b1;
    check32("t6_busy", {31'b0, busy}, 32'd1);
    @(negedge CPU_CLK);
    start = 1'b0;
    collect(3, 32'h200, 1'b0);
    check32("t6_csum_done", checksum, 32'h0);
    @(negedge CPU_CLK);
    check32("t6_csum_hold", checksum, 32'h0);
    check32("t6_idle_busy", {31'b0, busy}, 32'd0);
    check32("t6_idle_valid", {31'b0, m_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
